// File: rtl/fsm_counter_dispatcher_pkg.sv
// fsm_counter_dispatcher_pkg: state encoding and defaults shared by the dispatcher,
// the counter it drives and their benches.
package fsm_counter_dispatcher_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;
   localparam int CNT_W_DEF = 7;
endpackage

// File: rtl/fsm_counter_job_fifo.sv
// fsm_counter_job_fifo: synchronous job FIFO with a combinational head; pointers carry
// one extra wrap bit so full and empty are told apart without a separate count.
module fsm_counter_job_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [CNT_W-1:0] din,
   output logic [CNT_W-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [CNT_W-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             wr_en, rd_en;
   assign empty = wr_q == rd_q;
   assign full  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
   assign dout  = mem_q[rd_q[AW-1:0]];
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + (AW+1)'(1);
         if (rd_en) rd_q <= rd_q + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/fsm_counter_dispatcher.sv
// fsm_counter_dispatcher: queues count jobs and hands them one at a time to a counter
// over the run/done handshake, aborting a job whose done never arrives.
module fsm_counter_dispatcher
   import fsm_counter_dispatcher_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 512,
   parameter int STAT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [CNT_W-1:0]  i_push_num,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_push_err,
   output logic              o_run,
   output logic [CNT_W-1:0]  o_num_cnt,
   input  logic              i_idle,
   input  logic              i_running,
   input  logic              i_done,
   output logic              o_busy,
   output logic              o_job_done,
   output logic              o_timeout,
   output logic [STAT_W-1:0] o_done_cnt,
   output logic [STAT_W-1:0] o_abort_cnt
);
   localparam int WD_W = $clog2(TIMEOUT);
   state_e           state_q;
   logic [WD_W-1:0]  wd_q;
   logic [CNT_W-1:0] head;
   logic             push_ok, pop;
   logic             unused_running;
   assign unused_running = i_running;
   assign push_ok = i_push && !o_full && (i_push_num != '0);
   assign pop     = (state_q == S_IDLE) && !o_empty && i_idle;
   assign o_busy  = state_q != S_IDLE;
   fsm_counter_job_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .din   (i_push_num),
      .dout  (head),
      .full  (o_full),
      .empty (o_empty)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wd_q        <= '0;
         o_run       <= 1'b0;
         o_num_cnt   <= '0;
         o_push_err  <= 1'b0;
         o_job_done  <= 1'b0;
         o_timeout   <= 1'b0;
         o_done_cnt  <= '0;
         o_abort_cnt <= '0;
      end else begin
         o_push_err <= i_push && !push_ok;
         o_run      <= 1'b0;
         o_job_done <= 1'b0;
         o_timeout  <= 1'b0;
         case (state_q)
            S_IDLE: if (pop) begin
               o_num_cnt <= head;
               o_run     <= 1'b1;
               state_q   <= S_ISSUE;
            end
            S_ISSUE: begin
               wd_q    <= '0;
               state_q <= S_WAIT;
            end
            // done is checked first so it wins over a coincident watchdog expiry
            S_WAIT: if (i_done) begin
               o_job_done <= 1'b1;
               o_done_cnt <= (&o_done_cnt) ? o_done_cnt : o_done_cnt + STAT_W'(1);
               state_q    <= S_DONE;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               o_timeout   <= 1'b1;
               o_abort_cnt <= (&o_abort_cnt) ? o_abort_cnt : o_abort_cnt + STAT_W'(1);
               state_q     <= S_IDLE;
            end else begin
               wd_q <= wd_q + WD_W'(1);
            end
            S_DONE: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fsm_counter_dispatcher.sv
// tb_fsm_counter_dispatcher: directed jobs against a behavioural counter; a negedge
// monitor pops expected issues and completions from scoreboard queues.
module tb_fsm_counter_dispatcher;
   localparam int CNT_W = 7;
   localparam int DEPTH = 4;
   localparam int TO    = 512;
   localparam int STW   = 8;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             i_push = 1'b0;
   logic [CNT_W-1:0] i_push_num = '0;
   logic             o_full, o_empty, o_push_err, o_run, o_busy, o_job_done, o_timeout;
   logic [CNT_W-1:0] o_num_cnt;
   logic             i_idle, i_running;
   logic             cm_done = 1'b0;
   logic             cm_busy = 1'b0;
   logic [CNT_W-1:0] cm_left = '0;
   logic             hold = 1'b0;
   logic             hang = 1'b0;
   logic [STW-1:0]   o_done_cnt, o_abort_cnt;
   int               checks = 0;
   int               failures = 0;
   int               exp_num[$];
   int               exp_evt[$];
   int               mon_e, mon_a;
   always #5 clk = ~clk;
   fsm_counter_dispatcher #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TIMEOUT(TO), .STAT_W(STW)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_push      (i_push),
      .i_push_num  (i_push_num),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_push_err  (o_push_err),
      .o_run       (o_run),
      .o_num_cnt   (o_num_cnt),
      .i_idle      (i_idle),
      .i_running   (i_running),
      .i_done      (cm_done),
      .o_busy      (o_busy),
      .o_job_done  (o_job_done),
      .o_timeout   (o_timeout),
      .o_done_cnt  (o_done_cnt),
      .o_abort_cnt (o_abort_cnt)
   );
   // Counter model: runs num cycles then pulses done; hang makes it a stub that never answers.
   always @(posedge clk) begin
      cm_done <= 1'b0;
      if (reset) begin
         cm_busy <= 1'b0;
         cm_left <= '0;
      end else if (!cm_busy && o_run && !hang) begin
         cm_busy <= 1'b1;
         cm_left <= o_num_cnt;
      end else if (cm_busy) begin
         if (cm_left <= 1) begin
            cm_busy <= 1'b0;
            cm_done <= 1'b1;
         end else cm_left <= cm_left - 1'b1;
      end
   end
   assign i_idle    = hang | (!cm_busy && !hold);
   assign i_running = cm_busy;
   // Event codes: 1 = job done, 2 = timeout, 3 = both at once (never legal)
   always @(negedge clk) begin
      if (o_run) begin
         checks++;
         if (exp_num.size() == 0) begin
            failures++;
            $display("FAIL run_issue actual=%0d expected=none", o_num_cnt);
         end else begin
            mon_e = exp_num.pop_front();
            if (int'(o_num_cnt) != mon_e) begin
               failures++;
               $display("FAIL run_issue actual=%0d expected=%0d", o_num_cnt, mon_e);
            end
         end
      end
      if (o_job_done || o_timeout) begin
         checks++;
         mon_a = (o_job_done ? 1 : 0) + (o_timeout ? 2 : 0);
         if (exp_evt.size() == 0) begin
            failures++;
            $display("FAIL job_event actual=%0d expected=none", mon_a);
         end else begin
            mon_e = exp_evt.pop_front();
            if (mon_a != mon_e) begin
               failures++;
               $display("FAIL job_event actual=%0d expected=%0d", mon_a, mon_e);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask
   task automatic push_job(input int n, input int evt);
      i_push     = 1'b1;
      i_push_num = CNT_W'(n);
      if (evt != 0) begin
         exp_num.push_back(n);
         exp_evt.push_back(evt);
      end
      tick();
      i_push = 1'b0;
   endtask
   task automatic wait_idle(input int budget);
      int n = 0;
      while ((o_busy || !o_empty || cm_busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("wait_idle_bound", n, -1);
   endtask
   task automatic wait_run(input int budget, output int n);
      n = 0;
      while (!o_run && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("wait_run_bound", n, -1);
   endtask
   initial begin
      int n;
      bit seen;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_empty", o_empty, 1);
      chk("rst_full", o_full, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_run", o_run, 0);
      chk("rst_num", o_num_cnt, 0);
      chk("rst_push_err", o_push_err, 0);
      chk("rst_done_cnt", o_done_cnt, 0);
      chk("rst_abort_cnt", o_abort_cnt, 0);
      // single job: visible next cycle, issued the cycle after
      push_job(100, 1);
      chk("t1_empty_n1", o_empty, 0);
      chk("t1_run_n1", o_run, 0);
      tick();
      chk("t1_run_n2", o_run, 1);
      wait_idle(300);
      chk("t1_done_cnt", o_done_cnt, 1);
      // fill to full with the counter held busy, then overflow
      hold = 1'b1;
      push_job(3, 1);
      push_job(5, 1);
      push_job(7, 1);
      push_job(9, 1);
      chk("t2_full", o_full, 1);
      chk("t2_no_err", o_push_err, 0);
      push_job(11, 0);
      chk("t2_overflow_err", o_push_err, 1);
      chk("t2_still_full", o_full, 1);
      tick();
      chk("t2_err_one_cycle", o_push_err, 0);
      hold = 1'b0;
      wait_idle(400);
      chk("t2_done_cnt", o_done_cnt, 5);
      chk("t2_empty", o_empty, 1);
      // zero-count job is refused
      push_job(0, 0);
      chk("t3_zero_err", o_push_err, 1);
      chk("t3_zero_empty", o_empty, 1);
      repeat (4) tick();
      chk("t3_not_busy", o_busy, 0);
      // counter not idle: job waits, issue follows once idle returns
      hold = 1'b1;
      push_job(20, 1);
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (o_run) seen = 1'b1;
      end
      chk("t6_run_held", seen, 0);
      hold = 1'b0;
      seen = 1'b0;
      repeat (2) begin
         tick();
         if (o_run) seen = 1'b1;
      end
      chk("t6_run_after_idle", seen, 1);
      wait_idle(100);
      chk("t6_done_cnt", o_done_cnt, 6);
      // stub counter that never finishes: watchdog aborts, then the next job issues
      hang = 1'b1;
      push_job(30, 2);
      push_job(40, 2);
      wait_run(10, n);
      n = 0;
      while (!o_timeout && n < TO + 20) begin
         tick();
         n++;
      end
      chk("t4_timeout_cycles", n, TO + 1);
      chk("t4_abort_cnt1", o_abort_cnt, 1);
      chk("t4_busy_after_to", o_busy, 0);
      wait_run(10, n);
      chk("t4_next_issue", o_num_cnt, 40);
      wait_idle(TO + 20);
      chk("t4_abort_cnt2", o_abort_cnt, 2);
      chk("t4_done_cnt", o_done_cnt, 6);
      hang = 1'b0;
      // reset in the middle of a job with two more queued
      hold = 1'b1;
      push_job(50, 1);
      push_job(60, 1);
      push_job(70, 1);
      hold = 1'b0;
      wait_run(10, n);
      tick();
      tick();
      chk("t5_busy_pre", o_busy, 1);
      chk("t5_queued_pre", o_empty, 0);
      reset = 1'b1;
      tick();
      exp_num.delete();
      exp_evt.delete();
      chk("t5_empty", o_empty, 1);
      chk("t5_busy", o_busy, 0);
      chk("t5_done_cnt", o_done_cnt, 0);
      chk("t5_abort_cnt", o_abort_cnt, 0);
      reset = 1'b0;
      repeat (80) tick();
      chk("t5_quiet_busy", o_busy, 0);
      chk("sb_runs_left", exp_num.size(), 0);
      chk("sb_events_left", exp_evt.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
